// File: rtl/serial_add_sub_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial
// adder/subtractor. The controller drives the master side; the block is the slave.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_bout;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, carry_bout
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, carry_bout
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder/full-subtractor step per clock,
// LSB first, carry/borrow rippled through a single flop. The result is
// published only when the final bit is processed, so partial sums never show.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_add_sub_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             finish;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [CW-1:0]    cnt;
  logic             mode_q;
  logic             c;
  logic             c_next;
  logic             s;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath control; DONE accepts a new start just like IDLE
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One bit-cell: sum/difference bit and next carry/borrow from the operand LSBs.
  // Work register shifts right with the new bit entering at the MSB; written as
  // shift-then-overwrite so WIDTH=1 needs no empty slice.
  always_comb begin
    s = sa[0] ^ sb[0] ^ c;
    if (mode_q) c_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & c);
    else        c_next = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    work_next           = work >> 1;
    work_next[WIDTH-1]  = s;
  end

  // Operand capture, serial shifting, and result publication on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      work     <= '0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      c        <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else if (load) begin
      sa     <= bus.a;
      sb     <= bus.b;
      mode_q <= bus.mode;
      work   <= '0;
      cnt    <= '0;
      c      <= 1'b0;
    end else if (step) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      work <= work_next;
      c    <= c_next;
      cnt  <= cnt + CW'(1);
      if (finish) begin
        result_q <= work_next;
        carry_q  <= c_next;
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.result     = result_q;
  assign bus.carry_bout = carry_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at WIDTH=8 and WIDTH=1: vector tables
// for arithmetic and latency, plus hand-written handshake/reset sequences.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(8)) bus8 ();
  serial_add_sub_if #(.WIDTH(1)) bus1 ();

  serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_add_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       co;
  } vec8_t;

  typedef struct {
    logic mode;
    logic a;
    logic b;
    logic res;
    logic co;
  } vec1_t;

  vec8_t v8[7];
  vec1_t v1[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one WIDTH=8 operation; sample 1ns after each edge until done (bounded)
  task automatic op8(input logic m, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] prev, output int lat, output int busy_n,
                     output bit hold_ok, output bit excl_ok);
    lat = -1; busy_n = 0; hold_ok = 1'b1; excl_ok = 1'b1;
    @(negedge clk);
    bus8.start = 1'b1; bus8.mode = m; bus8.a = a; bus8.b = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int k = 0; k <= 20 && lat < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (bus8.busy) busy_n++;
      if (bus8.busy && bus8.done) excl_ok = 1'b0;
      if (bus8.done) lat = k;
      else if (bus8.result !== prev) hold_ok = 1'b0;
    end
  endtask

  task automatic op1(input logic m, input logic a, input logic b, output int lat);
    lat = -1;
    @(negedge clk);
    bus1.start = 1'b1; bus1.mode = m; bus1.a = a; bus1.b = b;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    for (int k = 0; k <= 10 && lat < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (bus1.done) lat = k;
    end
  endtask

  initial begin
    int      lat, busy_n, n_done, last_done;
    bit      hold_ok, excl_ok, ok;
    logic [7:0] prev, res_seen;
    logic    co_seen;

    v8[0] = '{1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0};
    v8[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
    v8[2] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1};
    v8[3] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b0};
    v8[4] = '{1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0};
    v8[5] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1};
    v8[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};

    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    v1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    v1[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v1[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    v1[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    bus8.start = 1'b0; bus8.mode = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.mode = 1'b0; bus1.a = '0; bus1.b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_result", 32'(bus8.result), 32'd0);
    check("rst_carry", 32'(bus8.carry_bout), 32'd0);
    check("rst_w1_result", 32'(bus1.result), 32'd0);

    // WIDTH=8 vector table; each op also checks the previous result is held
    prev = 8'h00;
    for (int i = 0; i < 7; i++) begin
      op8(v8[i].mode, v8[i].a, v8[i].b, prev, lat, busy_n, hold_ok, excl_ok);
      check($sformatf("w8_res[%0d]", i), 32'(bus8.result), 32'(v8[i].res));
      check($sformatf("w8_co[%0d]", i), 32'(bus8.carry_bout), 32'(v8[i].co));
      check($sformatf("w8_lat[%0d]", i), 32'(lat), 32'd8);
      check($sformatf("w8_busy[%0d]", i), 32'(busy_n), 32'd8);
      check($sformatf("w8_hold[%0d]", i), 32'(hold_ok), 32'd1);
      check($sformatf("w8_excl[%0d]", i), 32'(excl_ok), 32'd1);
      prev = v8[i].res;
    end

    // WIDTH=1 half adder / half subtractor truth tables
    for (int i = 0; i < 8; i++) begin
      op1(v1[i].mode, v1[i].a, v1[i].b, lat);
      check($sformatf("w1_res[%0d]", i), 32'(bus1.result), 32'(v1[i].res));
      check($sformatf("w1_co[%0d]", i), 32'(bus1.carry_bout), 32'(v1[i].co));
      check($sformatf("w1_lat[%0d]", i), 32'(lat), 32'd1);
    end

    // start and operand changes during RUN are ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b1; bus8.mode = 1'b0; bus8.a = 8'h12; bus8.b = 8'h34;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus8.start = 1'b1; bus8.mode = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = 8'h77; bus8.b = 8'h99;
    n_done = 0; res_seen = '0; co_seen = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        n_done++;
        res_seen = bus8.result;
        co_seen = bus8.carry_bout;
      end
    end
    check("ign_res", 32'(res_seen), 32'h46);
    check("ign_co", 32'(co_seen), 32'd0);
    check("ign_ndone", 32'(n_done), 32'd1);

    // start held high: done every 9 cycles, busy low only in DONE
    @(negedge clk);
    bus8.start = 1'b1; bus8.mode = 1'b0; bus8.a = 8'h3C; bus8.b = 8'h0F;
    @(posedge clk); #1;
    n_done = 0; last_done = -1; ok = 1'b1; hold_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (bus8.busy === bus8.done) hold_ok = 1'b0;
      if (bus8.done) begin
        if (last_done < 0) begin
          if (k != 8) ok = 1'b0;
        end else if (k - last_done != 9) begin
          ok = 1'b0;
        end
        last_done = k;
        n_done++;
        if (bus8.result !== 8'h4B) ok = 1'b0;
      end
    end
    check("b2b_ndone", 32'(n_done), 32'd4);
    check("b2b_period", 32'(ok), 32'd1);
    check("b2b_busy", 32'(hold_ok), 32'd1);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (12) @(posedge clk);

    // Reset in the 4th RUN cycle aborts without a done pulse
    @(negedge clk);
    bus8.start = 1'b1; bus8.mode = 1'b0; bus8.a = 8'hAA; bus8.b = 8'h55;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(bus8.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus8.busy), 32'd0);
    check("mid_rst_done", 32'(bus8.done), 32'd0);
    check("mid_rst_result", 32'(bus8.result), 32'd0);
    check("mid_rst_carry", 32'(bus8.carry_bout), 32'd0);
    ok = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) ok = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) ok = 1'b0;
    end
    check("rst_quiet", 32'(ok), 32'd1);
    op8(1'b0, 8'hAA, 8'h55, 8'h00, lat, busy_n, hold_ok, excl_ok);
    check("post_rst_res", 32'(bus8.result), 32'hFF);
    check("post_rst_co", 32'(bus8.carry_bout), 32'd0);
    check("post_rst_lat", 32'(lat), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
